dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed, big-endian data memory (64 bytes, word access).
- Port 0 is the CPU load/store path. Port 1 is the debug/loader path (memory preload, dump).
- Serialises accesses and drives the memory's DAddr/DataIn/RD/WR strobes.
- Range- and alignment-checks each request, and returns registered read data with a one-cycle ack.

Parameters:
- DEPTH, 64, memory size in bytes. Legal word addresses are 0 to DEPTH-4, in steps of 4.
- PORT1_HOLD, 0, when 1, port 1 keeps the grant for back-to-back requests (burst preload) until its req is low in IDLE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; level, held until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  32  port 0 byte address.
- wdata0  in  32  port 0 write data.
- rdata0  out  32  port 0 read data, valid while ack0=1.
- ack0  out  1  port 0 completion pulse, one cycle.
- err0  out  1  port 0 error, valid with ack0.
- req1, we1, addr1, wdata1, rdata1, ack1, err1: same as port 0, for port 1.
- mem_DAddr  out  32  memory address.
- mem_DataIn  out  32  memory write data.
- mem_RD  out  1  memory read enable.
- mem_WR  out  1  memory write enable; memory writes on the falling clk edge.
- mem_DataOut  in  32  memory read data, combinational from mem_DAddr when mem_RD=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; all outputs 0, including mem_* and rdata0/rdata1; the round-robin pointer points at port 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner:
    - Fixed priority by default: port 0 wins.
    - PORT1_HOLD=1 and the last grant went to port 1: port 1 wins if req1 is high.
  - Latch the winner id, we, addr and wdata, then go to ACCESS.
- Validity check, done in IDLE on the latched request: the request is invalid if addr[1:0]!=0 or addr>DEPTH-4.
- ACCESS (exactly one cycle):
  - mem_DAddr and mem_DataIn come from the latched registers.
  - mem_RD = valid & ~we; mem_WR = valid & we.
  - An invalid request drives both strobes 0.
  - At the next rising edge:
    - Capture mem_DataOut into the winner's rdata, reads only. On write or error, rdata keeps its old value.
    - Set the winner's ack=1 and err=~valid.
    - Go to RESP.
- RESP: ack/err high for this one cycle, strobes 0; the next edge returns to IDLE and clears ack/err.
- Timing: req is sampled at edge k; the memory access is in the cycle after edge k; ack is high in the cycle after edge k+1. Maximum throughput is one access per 3 cycles.
- Handshake:
  - The requester keeps req, we, addr and wdata stable from assertion until it sees ack; these are not sampled after IDLE.
  - The requester deasserts req in the cycle after ack, or keeps it high to start a new access.
  - Because IDLE re-samples, a req still high causes a repeat access.
- Ack exclusivity: at most one ack is high in any cycle; the non-winning port's ack/err stay 0.
- Simultaneous req0 and req1: one winner per IDLE. The loser stays pending and is served in the next IDLE, unless starved by the priority scheme.
- mem_DAddr and mem_DataIn hold the last latched values outside ACCESS. Strobes are low outside ACCESS.
- Reset during ACCESS: the state goes to IDLE and mem_WR drops immediately (asynchronously), so the falling-edge write of that cycle is suppressed. No ack is issued.
- Reset has no effect on memory contents.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer toggles to the non-winner after each grant; with both requests high, grants alternate 0,1,0,1. PORT1_HOLD overrides the pointer while port 1 keeps requesting.
- Undefined: fixed priority as above, and no pointer register is built.

Test Plan:
- Reset, then port 0 write: addr0=0x8, wdata0=0xDEADBEEF. Result: mem_WR high for one cycle with mem_DAddr=8; ack0 two edges after req; bytes 8..11 = DE,AD,BE,EF.
- Port 1 read of addr1=0x8 after the above: rdata1=0xDEADBEEF with ack1=1, err1=0; ack0 stays 0.
- req0 and req1 asserted together, held for 4 accesses:
  - Fixed priority: ack0 only, no ack1.
  - DMEM_ARB_RR_EN: acks alternate port0, port1, port0, port1.
- Bad accesses:
  - addr0=0x6 (misaligned) gives ack0=1, err0=1, and mem_RD and mem_WR never assert.
  - addr1=0x3C is legal (last word); addr1=0x40 gives err1=1.
- Reset asserted mid-ACCESS of a write to 0x10 with data 0x12345678: mem_WR drops at once, no ack, word 0x10 unchanged, busy=0.
- PORT1_HOLD=1, port 1 bursting 4 writes while req0 is held: port 1 gets all 4 grants back-to-back; port 0 gets the first ack after port 1 drops req1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 64-byte big-endian data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module dmem_arbiter #(
  parameter int DEPTH      = 64,
  parameter bit PORT1_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] mem_DAddr,
  output logic [31:0] mem_DataIn,
  output logic        mem_RD,
  output logic        mem_WR,
  input  logic [31:0] mem_DataOut,
  output logic        busy
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [31:0] LAST_A = 32'(DEPTH - 4);

  typedef struct packed {
    logic        id;
    logic        we;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0]  state_q;
  req_t        req_q, req_d;
  logic        win_d;
  logic        last1_q;
  logic [1:0]  ack_q, err_q;
  logic [31:0] rdata0_q, rdata1_q;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q;
`endif

  always_comb begin
    win_d = ~req0;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) win_d = ptr_q;
`endif
    // A port-1 burst keeps the grant until req1 drops in IDLE.
    if (PORT1_HOLD && last1_q && req1) win_d = 1'b1;
  end

  always_comb begin
    req_d.id    = win_d;
    req_d.we    = win_d ? we1    : we0;
    req_d.addr  = win_d ? addr1  : addr0;
    req_d.wdata = win_d ? wdata1 : wdata0;
    req_d.valid = (req_d.addr[1:0] == 2'b00) && (req_d.addr <= LAST_A);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      last1_q  <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req0 || req1) begin
          req_q   <= req_d;
          last1_q <= win_d;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (req_q.valid && !req_q.we) begin
            if (req_q.id) rdata1_q <= mem_DataOut;
            else          rdata0_q <= mem_DataOut;
          end
          ack_q[req_q.id] <= 1'b1;
          err_q[req_q.id] <= ~req_q.valid;
          state_q         <= RESP;
        end
        RESP: begin
          ack_q   <= '0;
          err_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                               ptr_q <= 1'b0;
    else if (state_q == IDLE && (req0 || req1)) ptr_q <= ~win_d;
  end
`endif

  // Strobes decode straight from state so an async reset kills mem_WR before the falling edge.
  assign mem_RD     = (state_q == ACCESS) && req_q.valid && !req_q.we;
  assign mem_WR     = (state_q == ACCESS) && req_q.valid &&  req_q.we;
  assign mem_DAddr  = req_q.addr;
  assign mem_DataIn = req_q.wdata;
  assign busy       = (state_q != IDLE);
  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign err0       = err_q[0];
  assign err1       = err_q[1];
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: default instance plus a PORT1_HOLD=1 instance.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  logic        req0, we0, req1, we1, ack0, ack1, err0, err1, mem_RD, mem_WR, busy;
  logic [31:0] addr0, wdata0, addr1, wdata1, rdata0, rdata1;
  logic [31:0] mem_DAddr, mem_DataIn, mem_DataOut;

  logic        b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1, b_err0, b_err1;
  logic        b_RD, b_WR, b_busy;
  logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1, b_rdata0, b_rdata1;
  logic [31:0] b_DAddr, b_DataIn;
  logic [31:0] b_DataOut = 32'h0;

  dmem_arbiter #(.DEPTH(64), .PORT1_HOLD(1'b0)) dut (
    .clk(clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1), .err1(err1),
    .mem_DAddr(mem_DAddr), .mem_DataIn(mem_DataIn), .mem_RD(mem_RD), .mem_WR(mem_WR),
    .mem_DataOut(mem_DataOut), .busy(busy));

  dmem_arbiter #(.DEPTH(64), .PORT1_HOLD(1'b1)) dut_hold (
    .clk(clk), .Reset(Reset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .rdata0(b_rdata0), .ack0(b_ack0), .err0(b_err0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .rdata1(b_rdata1), .ack1(b_ack1), .err1(b_err1),
    .mem_DAddr(b_DAddr), .mem_DataIn(b_DataIn), .mem_RD(b_RD), .mem_WR(b_WR),
    .mem_DataOut(b_DataOut), .busy(b_busy));

  // Big-endian byte memory: falling-edge write, combinational read.
  logic [7:0] mem [0:63];
  logic [5:0] ma;
  assign ma = {mem_DAddr[5:2], 2'b00};
  assign mem_DataOut = mem_RD ? {mem[ma], mem[ma+6'd1], mem[ma+6'd2], mem[ma+6'd3]} : 32'h0;
  always @(negedge clk) if (mem_WR) begin
    mem[ma]      <= mem_DataIn[31:24];
    mem[ma+6'd1] <= mem_DataIn[23:16];
    mem[ma+6'd2] <= mem_DataIn[15:8];
    mem[ma+6'd3] <= mem_DataIn[7:0];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  logic sb_b[$];

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!Reset && (ack0 || ack1)) begin
      chk("ack_excl", 32'(ack0 & ack1), 0);
      if (sb.size() == 0) chk("ack_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(e.port));
        chk("err", 32'(e.port ? err1 : err0), 32'(e.err));
        chk("err_other", 32'(e.port ? err0 : err1), 0);
        if (e.rd) chk("rdata", e.port ? rdata1 : rdata0, e.rdata);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic p;
    if (!Reset && (b_ack0 || b_ack1)) begin
      chk("hold_excl", 32'(b_ack0 & b_ack1), 0);
      if (sb_b.size() == 0) chk("hold_unexpected", 1, 0);
      else begin
        p = sb_b.pop_front();
        chk("hold_port", 32'(b_ack1), 32'(p));
      end
    end
  end

  // One complete access on the default instance with fixed 3-cycle timing.
  task automatic access(input bit p, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input bit xerr, input logic [31:0] xrd);
    exp_t e;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    e.port = p; e.err = xerr; e.rd = !w && !xerr; e.rdata = xrd;
    sb.push_back(e);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
    @(negedge clk);
    chk("acc_busy", 32'(busy), 1);
    chk("acc_rd", 32'(mem_RD), 32'(!w && !xerr));
    chk("acc_wr", 32'(mem_WR), 32'(w && !xerr));
    chk("acc_addr", mem_DAddr, a);
    if (w) chk("acc_wdata", mem_DataIn, wd);
    @(negedge clk);
    chk("ack_lat", 32'(p ? ack1 : ack0), 1);
    chk("resp_strb", 32'({mem_RD, mem_WR}), 0);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    int n;
    int n1;
    bit done0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    Reset = 1'b1;
    {req0, we0, req1, we1} = '0; addr0 = 0; wdata0 = 0; addr1 = 0; wdata1 = 0;
    {b_req0, b_we0, b_req1, b_we1} = '0; b_addr0 = 0; b_wdata0 = 0; b_addr1 = 0; b_wdata1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'({ack0, ack1, err0, err1}), 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_daddr", mem_DAddr, 0);
    chk("rst_datain", mem_DataIn, 0);
    chk("rst_strb", 32'({mem_RD, mem_WR, busy}), 0);
    Reset = 1'b0;

    access(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("mem_be", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF);

    // Both ports request together, held for four acks.
    @(negedge clk);
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) sb.push_back('{port: i[0], err: 1'b0, rd: 1'b1, rdata: 32'hDEADBEEF});
`else
    for (int i = 0; i < 4; i++) sb.push_back('{port: 1'b0, err: 1'b0, rd: 1'b1, rdata: 32'hDEADBEEF});
`endif
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("both_acks", n, 4);
    repeat (4) @(negedge clk);
    chk("both_sb_empty", sb.size(), 0);

    access(1'b0, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0);
    access(1'b1, 1'b1, 32'h3C, 32'hCAFEF00D, 1'b0, 32'h0);
    access(1'b0, 1'b0, 32'h3C, 32'h0, 1'b0, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h3C, 32'h0, 1'b0, 32'hCAFEF00D);
    access(1'b1, 1'b1, 32'h40, 32'h11111111, 1'b1, 32'h0);
    chk("rdata1_hold", rdata1, 32'hCAFEF00D);
    chk("mem_last", {mem[60], mem[61], mem[62], mem[63]}, 32'hCAFEF00D);

    // Reset lands in the middle of a write ACCESS cycle.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h12345678;
    @(posedge clk);
    #1 chk("pre_rst_wr", 32'(mem_WR), 1);
    #1 Reset = 1'b1;
    #1 chk("rst_wr_drop", 32'(mem_WR), 0);
    chk("rst_busy", 32'(busy), 0);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_ack", 32'({ack0, ack1}), 0);
    chk("rst_mem10", {mem[16], mem[17], mem[18], mem[19]}, 32'h0);
    chk("rst_sb_empty", sb.size(), 0);

    // PORT1_HOLD burst: four port-1 writes back-to-back while port 0 waits.
    @(negedge clk);
    for (int i = 0; i < 4; i++) sb_b.push_back(1'b1);
    sb_b.push_back(1'b0);
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 32'h20; b_wdata1 = 32'hA5A5A5A5;
    @(negedge clk);
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 32'h24; b_wdata0 = 32'h5A5A5A5A;
    n1 = 0; done0 = 1'b0;
    for (int c = 0; c < 80 && !done0; c++) begin
      @(negedge clk);
      if (b_ack1) begin
        n1++;
        if (n1 == 4) b_req1 = 1'b0;
      end
      if (b_ack0) begin
        done0 = 1'b1;
        b_req0 = 1'b0;
      end
    end
    chk("hold_p0_done", 32'(done0), 1);
    chk("hold_p1_acks", n1, 4);
    repeat (3) @(negedge clk);
    chk("hold_sb_empty", sb_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
